// File: rtl/scr1_pipe_vlsu.sv
`default_nettype none
// ============================================================================
// Module   : scr1_pipe_vlsu
// Purpose  : Vector load/store unit. Splits one LANES-element request into
//            32-bit DMEM beats at addr + i*stride, keeps up to MAX_OUTST
//            beats in flight and returns the vector or a precise exception.
// Options  : SCR1_VLSU_FAULT_IDX_EN adds vlsu2exu_fault_idx.
// Revision : 1.0 - initial release
// ============================================================================
module scr1_pipe_vlsu #(
    parameter int LANES     = 4,
    parameter int MAX_OUTST = 2,
    parameter int AWIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     exu2vlsu_req,
    input  logic                     exu2vlsu_we,
    input  logic [AWIDTH-1:0]        exu2vlsu_addr,
    input  logic [31:0]              exu2vlsu_stride,
    input  logic [LANES*32-1:0]      exu2vlsu_s_data,
    output logic                     vlsu2exu_rdy,
    output logic [LANES*32-1:0]      vlsu2exu_l_data,
    output logic                     vlsu2exu_exc,
    output logic [3:0]               vlsu2exu_exc_code,
`ifdef SCR1_VLSU_FAULT_IDX_EN
    output logic [$clog2(LANES)-1:0] vlsu2exu_fault_idx,
`endif
    output logic                     vlsu_busy,
    output logic                     vlsu2dmem_req,
    output logic                     vlsu2dmem_we,
    output logic [AWIDTH-1:0]        vlsu2dmem_addr,
    output logic [31:0]              vlsu2dmem_wdata,
    input  logic                     dmem2vlsu_req_ack,
    input  logic [31:0]              dmem2vlsu_rdata,
    input  logic [1:0]               dmem2vlsu_resp
);

    localparam int            IDXW    = $clog2(LANES);
    localparam int            CW      = IDXW + 1;
    localparam logic [CW-1:0] LANES_C = CW'(LANES);
    localparam logic [2:0]    MAXO_C  = 3'(MAX_OUTST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                   state_q,     state_d;
    logic                     we_q,        we_d;
    logic [AWIDTH-1:0]        baddr_q,     baddr_d;
    logic [31:0]              stride_q,    stride_d;
    logic [LANES-1:0][31:0]   sdata_q,     sdata_d;
    logic [LANES-1:0][31:0]   lbuf_q,      lbuf_d;
    logic [CW-1:0]            issue_idx_q, issue_idx_d;
    logic [IDXW-1:0]          resp_idx_q,  resp_idx_d;
    logic [2:0]               outst_q,     outst_d;
    logic                     err_q,       err_d;
`ifdef SCR1_VLSU_FAULT_IDX_EN
    logic [IDXW-1:0]          fault_idx_q, fault_idx_d;
`endif

    logic [AWIDTH-1:0] w_stride_ext;
    logic              w_misalign;
    logic              w_in_xfer;
    logic              w_resp_vld;
    logic              w_resp_err;
    logic              w_err_now;
    logic              w_beat_req;
    logic              w_beat_acc;
    logic              w_done;

    // The running beat address advances by the sign-extended stride; wrap is intended.
    generate
        if (AWIDTH > 32) begin : g_stride_sext
            assign w_stride_ext = {{(AWIDTH-32){stride_q[31]}}, stride_q};
        end else begin : g_stride_trunc
            assign w_stride_ext = stride_q[AWIDTH-1:0];
        end
    endgenerate

    assign w_misalign = exu2vlsu_req & (state_q == ST_IDLE)
                      & ((|exu2vlsu_addr[1:0]) | (|exu2vlsu_stride[1:0]));
    assign w_in_xfer  = (state_q == ST_ISSUE) | (state_q == ST_DRAIN);
    assign w_resp_vld = w_in_xfer & (outst_q != 3'd0)
                      & ((dmem2vlsu_resp == 2'b01) | (dmem2vlsu_resp == 2'b10));
    assign w_resp_err = w_resp_vld & (dmem2vlsu_resp == 2'b10);
    // An error arriving this cycle already blocks the next beat.
    assign w_err_now  = err_q | w_resp_err;
    assign w_beat_req = (state_q == ST_ISSUE) & (issue_idx_q < LANES_C)
                      & (outst_q < MAXO_C) & ~w_err_now;
    assign w_beat_acc = w_beat_req & dmem2vlsu_req_ack;
    assign w_done     = (state_q == ST_DONE);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        baddr_d     = baddr_q;
        stride_d    = stride_q;
        sdata_d     = sdata_q;
        lbuf_d      = lbuf_q;
        issue_idx_d = issue_idx_q;
        resp_idx_d  = resp_idx_q;
        err_d       = err_q;
        outst_d     = outst_q + {2'b00, w_beat_acc} - {2'b00, w_resp_vld};
`ifdef SCR1_VLSU_FAULT_IDX_EN
        fault_idx_d = fault_idx_q;
`endif

        if (w_beat_acc) begin
            issue_idx_d = issue_idx_q + 1'b1;
            baddr_d     = baddr_q + w_stride_ext;
        end

        if (w_resp_vld) begin
            resp_idx_d = resp_idx_q + 1'b1;
            if (w_resp_err) begin
                err_d = 1'b1;
`ifdef SCR1_VLSU_FAULT_IDX_EN
                if (!err_q) begin
                    fault_idx_d = resp_idx_q;
                end
`endif
            end else if (!we_q && !err_q) begin
                lbuf_d[resp_idx_q] = dmem2vlsu_rdata;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (exu2vlsu_req && !w_misalign) begin
                    we_d     = exu2vlsu_we;
                    baddr_d  = exu2vlsu_addr;
                    stride_d = exu2vlsu_stride;
                    sdata_d  = exu2vlsu_s_data;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (err_d || (issue_idx_d == LANES_C)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outst_d == 3'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                issue_idx_d = '0;
                resp_idx_d  = '0;
                err_d       = 1'b0;
`ifdef SCR1_VLSU_FAULT_IDX_EN
                fault_idx_d = '0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            baddr_q     <= '0;
            stride_q    <= '0;
            sdata_q     <= '0;
            lbuf_q      <= '0;
            issue_idx_q <= '0;
            resp_idx_q  <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
`ifdef SCR1_VLSU_FAULT_IDX_EN
            fault_idx_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            baddr_q     <= baddr_d;
            stride_q    <= stride_d;
            sdata_q     <= sdata_d;
            lbuf_q      <= lbuf_d;
            issue_idx_q <= issue_idx_d;
            resp_idx_q  <= resp_idx_d;
            outst_q     <= outst_d;
            err_q       <= err_d;
`ifdef SCR1_VLSU_FAULT_IDX_EN
            fault_idx_q <= fault_idx_d;
`endif
        end
    end

    assign vlsu2exu_rdy    = w_misalign | w_done;
    assign vlsu2exu_exc    = w_misalign | (w_done & err_q);
    assign vlsu2exu_l_data = w_done ? lbuf_q : '0;
    assign vlsu_busy       = (state_q != ST_IDLE);

    always_comb begin
        vlsu2exu_exc_code = 4'd0;
        if (w_misalign) begin
            vlsu2exu_exc_code = exu2vlsu_we ? 4'd6 : 4'd4;
        end else if (w_done && err_q) begin
            vlsu2exu_exc_code = we_q ? 4'd7 : 4'd5;
        end
    end

`ifdef SCR1_VLSU_FAULT_IDX_EN
    assign vlsu2exu_fault_idx = (w_done && err_q) ? fault_idx_q : '0;
`endif

    assign vlsu2dmem_req   = w_beat_req;
    assign vlsu2dmem_we    = w_beat_req & we_q;
    assign vlsu2dmem_addr  = baddr_q;
    assign vlsu2dmem_wdata = sdata_q[issue_idx_q[IDXW-1:0]];

`ifdef SCR1_SIM_ENV
    // A response with nothing in flight is a memory protocol error.
    a_unsolicited_resp: assert property (@(posedge clk) disable iff (!rst_n)
        ((dmem2vlsu_resp == 2'b01) || (dmem2vlsu_resp == 2'b10))
        |-> (w_in_xfer && (outst_q != 3'd0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_scr1_pipe_vlsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_scr1_pipe_vlsu
// Purpose  : Scoreboard bench for scr1_pipe_vlsu with a DMEM responder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scr1_pipe_vlsu;

    localparam int LANES     = 4;
    localparam int MAX_OUTST = 2;
    localparam int AWIDTH    = 32;
    localparam int DW        = LANES * 32;
    localparam int IDXW      = $clog2(LANES);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req = 1'b0;
    logic            we = 1'b0;
    logic [31:0]     addr = '0;
    logic [31:0]     stride = '0;
    logic [DW-1:0]   sdata = '0;
    logic            rdy;
    logic [DW-1:0]   l_data;
    logic            exc;
    logic [3:0]      exc_code;
    logic            busy;
    logic            dreq;
    logic            dwe;
    logic [31:0]     daddr;
    logic [31:0]     dwdata;
    logic            dack = 1'b0;
    logic [31:0]     drdata = '0;
    logic [1:0]      dresp = 2'b00;
`ifdef SCR1_VLSU_FAULT_IDX_EN
    logic [IDXW-1:0] fault_idx;
`endif

    scr1_pipe_vlsu #(.LANES(LANES), .MAX_OUTST(MAX_OUTST), .AWIDTH(AWIDTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .exu2vlsu_req      (req),
        .exu2vlsu_we       (we),
        .exu2vlsu_addr     (addr),
        .exu2vlsu_stride   (stride),
        .exu2vlsu_s_data   (sdata),
        .vlsu2exu_rdy      (rdy),
        .vlsu2exu_l_data   (l_data),
        .vlsu2exu_exc      (exc),
        .vlsu2exu_exc_code (exc_code),
`ifdef SCR1_VLSU_FAULT_IDX_EN
        .vlsu2exu_fault_idx(fault_idx),
`endif
        .vlsu_busy         (busy),
        .vlsu2dmem_req     (dreq),
        .vlsu2dmem_we      (dwe),
        .vlsu2dmem_addr    (daddr),
        .vlsu2dmem_wdata   (dwdata),
        .dmem2vlsu_req_ack (dack),
        .dmem2vlsu_rdata   (drdata),
        .dmem2vlsu_resp    (dresp)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } beat_t;
    typedef struct { logic exc; logic [3:0] code; logic [DW-1:0] data; logic chk_data; int fidx; } res_t;
    typedef struct { logic [31:0] data; logic err; int due; } pend_t;

    beat_t       exp_beat[$];
    res_t        exp_res[$];
    pend_t       pend[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] mdl [logic [31:0]];
    logic [DW-1:0] mdl_buf = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_from = 0;
    int cur_err  = -1;
    int cur_lat  = 1;
    int beat_n   = 0;
    int rdy_cyc  = 0;
    int rdy_cnt  = 0;
    int max_out  = 0;
    int gate_viol = 0;
    bit done_seen = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : (a ^ 32'h5A5A_0000);
    endfunction

    // DMEM responder and output monitor; drives on the falling edge, samples 1 later.
    initial begin
        pend_t p;
        beat_t b;
        res_t  r;
        bit    resp_now;
        int    size0;
        forever begin
            @(negedge clk);
            cyc++;
            resp_now = 1'b0;
            if (!rst_n) begin
                dresp = 2'b00;
                dack  = 1'b0;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    dresp    = pend[0].err ? 2'b10 : 2'b01;
                    drdata   = pend[0].data;
                    resp_now = 1'b1;
                end else begin
                    dresp  = 2'b00;
                    drdata = '0;
                end
                dack = (cyc >= ack_from);
                #1;
                size0 = pend.size();
                if (dreq && size0 >= MAX_OUTST) gate_viol++;
                if (resp_now) void'(pend.pop_front());
                if (dreq && dack) begin
                    if (exp_beat.size() == 0) begin
                        check("unexp_beat", dreq, 0);
                    end else begin
                        b = exp_beat.pop_front();
                        check("beat_addr", daddr, b.addr);
                        check("beat_we", dwe, b.we);
                        if (b.we) check("beat_wdata", dwdata, b.wdata);
                    end
                    p.err = (beat_n == cur_err);
                    p.due = cyc + cur_lat;
                    p.data = dwe ? 32'h0 : mem_rd(daddr);
                    if (dwe) mem[daddr] = dwdata;
                    pend.push_back(p);
                    beat_n++;
                end
                if (pend.size() > max_out) max_out = pend.size();
                if (rdy) begin
                    rdy_cnt++;
                    rdy_cyc = cyc;
                    done_seen = 1'b1;
                    if (exp_res.size() == 0) begin
                        check("unexp_rdy", rdy, 0);
                    end else begin
                        r = exp_res.pop_front();
                        check("exc", exc, r.exc);
                        check("exc_code", exc_code, r.code);
                        if (r.chk_data) check("l_data", l_data, r.data);
`ifdef SCR1_VLSU_FAULT_IDX_EN
                        check("fault_idx", fault_idx, r.fidx);
`endif
                    end
                end
            end
        end
    end

    task automatic run_op(input logic op_we, input logic [31:0] a0, input logic [31:0] st,
                          input logic [DW-1:0] sd, input int err_beat, input int lat,
                          input int stall, input int exp_lat);
        res_t        r;
        beat_t       b;
        logic [31:0] a;
        int          nb;
        int          start;
        r.exc = 1'b0; r.code = 4'd0; r.chk_data = 1'b1; r.fidx = 0; r.data = '0;
        if ((a0[1:0] != 2'b00) || (st[1:0] != 2'b00)) begin
            r.exc = 1'b1; r.code = op_we ? 4'd6 : 4'd4; r.chk_data = 1'b0;
        end else begin
            nb = (err_beat >= 0) ? err_beat + 1 : LANES;
            a  = a0;
            for (int i = 0; i < nb; i++) begin
                b.addr = a; b.we = op_we; b.wdata = sd[i*32 +: 32];
                exp_beat.push_back(b);
                if (i != err_beat) begin
                    if (op_we) mdl[a] = sd[i*32 +: 32];
                    else       mdl_buf[i*32 +: 32] = mdl_rd(a);
                end
                a = a + st;
            end
            if (err_beat >= 0) begin
                r.exc = 1'b1; r.code = op_we ? 4'd7 : 4'd5; r.fidx = err_beat;
            end
            r.data = mdl_buf;
        end
        exp_res.push_back(r);
        @(posedge clk); #1;
        cur_err = err_beat; cur_lat = lat; beat_n = 0; done_seen = 1'b0;
        rdy_cnt = 0; max_out = 0; gate_viol = 0;
        ack_from = cyc + 2 + stall;
        start = cyc + 1;
        req = 1'b1; we = op_we; addr = a0; stride = st; sdata = sd;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (done_seen) break;
        end
        #1 req = 1'b0;
        check("timeout", done_seen, 1);
        if (!done_seen) begin
            exp_res.delete();
            exp_beat.delete();
        end
        if (exp_lat > 0) check("latency", rdy_cyc - start + 1, exp_lat);
        check("beats_left", exp_beat.size(), 0);
        check("outst_max", max_out > MAX_OUTST, 0);
        check("req_gate", gate_viol, 0);
        repeat (3) @(posedge clk);
        check("rdy_pulses", rdy_cnt, 1);
        check("pend_left", pend.size(), 0);
    endtask

    initial begin
        beat_t b;
        logic [DW-1:0] dv;
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        beat_t       b;
        logic [31:0] a;
        for (int i = 0; i < LANES; i++) begin
            mem[32'h100 + 32'(4*i)] = 32'hA0A0_0000 + 32'(i);
            mdl[32'h100 + 32'(4*i)] = 32'hA0A0_0000 + 32'(i);
        end
        #1;
        check("rst_rdy", rdy, 0);
        check("rst_exc", exc, 0);
        check("rst_code", exc_code, 0);
        check("rst_busy", busy, 0);
        check("rst_dreq", dreq, 0);
        check("rst_ldata", l_data, 0);
        check("rst_daddr", daddr, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_op(1'b0, 32'h100, 32'd4, '0, -1, 1, 0, LANES + 3);
        run_op(1'b1, 32'h200, -32'sd16,
               {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000}, -1, 1, 0, LANES + 3);
        run_op(1'b0, 32'h1D0, 32'd16, '0, -1, 1, 0, 0);
        run_op(1'b0, 32'h102, 32'd4, '0, -1, 1, 0, 1);
        run_op(1'b1, 32'h200, 32'd6, '0, -1, 1, 0, 1);
        run_op(1'b0, 32'h100, 32'd4, '0, 2, 1, 0, 0);
        run_op(1'b1, 32'h400, 32'd8, {32'h4, 32'h3, 32'h2, 32'h1}, 1, 1, 0, 0);
        run_op(1'b0, 32'h100, 32'd4, '0, -1, 5, 3, 0);

        // Reset in the middle of a load after two beats have been accepted.
        a = 32'h300;
        for (int i = 0; i < LANES; i++) begin
            b.addr = a; b.we = 1'b0; b.wdata = '0;
            exp_beat.push_back(b);
            a = a + 32'd4;
        end
        @(posedge clk); #1;
        cur_err = -1; cur_lat = 1; beat_n = 0; ack_from = cyc + 2;
        req = 1'b1; we = 1'b0; addr = 32'h300; stride = 32'd4; sdata = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #2;
            if (beat_n >= 2) break;
        end
        check("rst_mid_beats", beat_n, 2);
        @(posedge clk); #1;
        rst_n = 1'b0; req = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rdy", rdy, 0);
        check("rst_mid_dreq", dreq, 0);
        pend.delete();
        exp_beat.delete();
        mdl_buf = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        run_op(1'b0, 32'h100, 32'd4, '0, -1, 1, 0, LANES + 3);

        run_op(1'b0, 32'hFFFF_FFF8, 32'd4, '0, -1, 1, 0, LANES + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scr1_pipe_vlsu.md
Name: scr1_pipe_vlsu

Overview:
Parametrised vector load/store unit that succeeds the single-beat LSU in the SCR1 pipeline. It takes one LANES-element vector load/store from EXU and splits it into LANES 32-bit DMEM beats at addresses addr + i*stride. It keeps up to MAX_OUTST beats in flight and returns the assembled vector, or a precise exception, to EXU.

Parameters:
LANES, 4, vector elements per request (power of 2, >=2)
MAX_OUTST, 2, max DMEM beats issued but not yet responded (1..4)
AWIDTH, 32, DMEM address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
exu2vlsu_req  in  1  vector request; held stable with all operands until vlsu2exu_rdy
exu2vlsu_we  in  1  1 = store, 0 = load
exu2vlsu_addr  in  AWIDTH  base byte address
exu2vlsu_stride  in  32  signed byte stride
exu2vlsu_s_data  in  LANES*32  store data; element i at bits [32i+31:32i]
vlsu2exu_rdy  out  1  one-cycle completion pulse
vlsu2exu_l_data  out  LANES*32  load result
vlsu2exu_exc  out  1  exception, valid with rdy
vlsu2exu_exc_code  out  4  4 LD misalign, 5 LD access fault, 6 ST misalign, 7 ST access fault
vlsu_busy  out  1  FSM not IDLE
vlsu2dmem_req  out  1  beat request
vlsu2dmem_we  out  1  beat direction
vlsu2dmem_addr  out  AWIDTH  beat address
vlsu2dmem_wdata  out  32  beat store data
dmem2vlsu_req_ack  in  1  beat accepted when req & req_ack
dmem2vlsu_rdata  in  32  beat load data
dmem2vlsu_resp  in  2  00 none, 01 RDY_OK, 10 RDY_ER; responses return in issue order

Behaviour:
- Reset: FSM=IDLE, issue_idx=0, resp_idx=0, outst=0, l_data buffer=0. All outputs 0 (exc_code=0).
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - Misalign check: req & (addr[1:0]!=0 | stride[1:0]!=0) -> combinational rdy=1, exc=1, code 4 (load) or 6 (store). No DMEM request. Stay IDLE.
  - Otherwise req -> capture cmd, addr, stride, and s_data. Go to ISSUE. No DMEM request in this cycle.
- ISSUE:
  - dmem_req = (issue_idx<LANES) & (outst<MAX_OUTST) & ~err_seen.
  - Beat address = base + issue_idx*stride, modulo 2^AWIDTH (wrap allowed). Stride 0 is legal.
  - wdata = element issue_idx.
  - req & req_ack -> issue_idx++.
  - outst += accepted beat - response received. Both in the same cycle leave outst unchanged.
- Responses:
  - RDY_OK on a load -> element resp_idx of the buffer = rdata.
  - Every response -> resp_idx++.
  - RDY_ER -> set err_seen, record fault index = resp_idx and code 5/7; the element is not written.
  - After an error, no further beats are issued.
- ISSUE->DRAIN when err_seen or issue_idx==LANES.
- DRAIN->DONE when outst==0, including the cycle where the last response arrives.
- DONE: rdy=1 for one cycle; exc=err_seen; l_data = buffer (elements after a fault keep their prior value). Go to IDLE and clear the indices and err_seen.
- Timing:
  - No backpressure, fully pipelined, 1-cycle DMEM latency, MAX_OUTST>=2: LANES+3 cycles from req to rdy.
  - MAX_OUTST=1: one beat per 2 cycles.
- Unsolicited response (outst==0 outside DRAIN/ISSUE) is a protocol error: ignored, flagged by an SVA under SCR1_SIM_ENV.
- EXU drops req the cycle after rdy. req while busy is ignored (operands are already captured).
- Reset mid-operation: immediate return to reset state; late DMEM responses after reset are the memory's responsibility.

Optional Feature:
SCR1_VLSU_FAULT_IDX_EN:
- Defined: adds output vlsu2exu_fault_idx [$clog2(LANES)-1:0]. It carries the faulting element index, valid with rdy & exc (codes 5/7), and is 0 for misalign and success.
- Undefined: port and index register absent. Exception behaviour is otherwise identical.

Test Plan:
- Load, addr 0x100, stride 4, mem[0x100..0x10C]=A0..A3, req_ack=1, resp next cycle -> beats 0x100,0x104,0x108,0x10C; rdy at cycle 7 (LANES+3); l_data={A3,A2,A1,A0}; exc=0.
- Store, addr 0x200, stride -16, s_data={D3..D0} -> writes D0@0x200, D1@0x1F0, D2@0x1E0, D3@0x1D0; rdy, exc=0.
- Load, addr 0x102 -> same-cycle rdy=1, exc=1, code 4, vlsu2dmem_req never asserted. Store, stride 6 -> code 6.
- Load, beat 2 returns RDY_ER, beats 0/1 OK (MAX_OUTST=2) -> beat 3 never issued; outst drains to 0; rdy with exc=1, code 5, fault_idx=2.
- req_ack low 3 cycles, then responses delayed 4 cycles -> outst never exceeds MAX_OUTST; dmem_req low while outst==MAX_OUTST; data still correct and in order.
- rst_n asserted after beat 1 accepted -> next cycle busy=0, rdy=0, req=0; new request after reset completes normally. Also addr 0xFFFFFFF8, stride 4 -> addresses wrap to 0x0, 0x4.
